// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the write-through dcache.
package dcache_pkg;

  typedef enum logic [2:0] {
    ST_LOOKUP    = 3'd0,
    ST_WRITE_REQ = 3'd1,
    ST_FILL_REQ  = 3'd2,
    ST_FILL_WAIT = 3'd3,
    ST_FILL_DONE = 3'd4
  } state_e;

  localparam int OFFSET_BITS    = 3;
  localparam int DEF_INDEX_BITS = 9;
  localparam int TAG_BITS       = 32 - DEF_INDEX_BITS - OFFSET_BITS - 2;

  function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [31:0] addr);
    return addr[4:2];
  endfunction

  // Index and tag come back unmasked; callers slice them to their own widths.
  function automatic logic [31:0] addr_index(input logic [31:0] addr);
    return {5'd0, addr[31:5]};
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_bits);
    return addr >> (index_bits + 5);
  endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// Line-wide data array: byte-masked word writes from the CPU and whole-line
// writes from memory fills, assembled beat by beat in a line register.
module dcache_data_ram
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 9,
  parameter int LINE_BEATS = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [INDEX_BITS-1:0]  rd_idx_i,
  output logic [255:0]           rd_line_o,
  input  logic                   wr_en_i,
  input  logic [INDEX_BITS-1:0]  wr_idx_i,
  input  logic [OFFSET_BITS-1:0] wr_off_i,
  input  logic [3:0]             wr_mask_i,
  input  logic [31:0]            wr_data_i,
  input  logic                   fill_valid_i,
  input  logic [INDEX_BITS-1:0]  fill_idx_i,
  input  logic [127:0]           fill_data_i,
  output logic                   fill_last_o,
  output logic [255:0]           fill_line_o
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int CNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

  logic [255:0]     mem [LINES];
  logic [CNT_W-1:0] beat_q;
  logic [255:0]     line_q, line_d;

  assign fill_last_o = fill_valid_i && (beat_q == CNT_W'(LINE_BEATS - 1));
  assign fill_line_o = line_q;

  always_comb begin
    line_d = line_q;
    if (fill_valid_i) line_d[beat_q*128 +: 128] = fill_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q <= '0;
      line_q <= '0;
    end else begin
      line_q <= line_d;
      if (fill_valid_i) beat_q <= fill_last_o ? '0 : beat_q + 1'b1;
    end
  end

  // The last beat is merged combinationally so the line lands in one write.
  always_ff @(posedge clk_i) begin
    if (fill_last_o) begin
      mem[fill_idx_i] <= line_d;
    end else if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask_i[b]) mem[wr_idx_i][wr_off_i*32 + b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end
    end
    rd_line_o <= mem[rd_idx_i];
  end

endmodule

// File: rtl/wt_dcache_responder.sv
// Direct-mapped write-through, no-write-allocate dcache for the Memory151 CPU port.
// Optional read hit/miss counters are built when DCACHE_STATS_EN is defined.
module wt_dcache_responder
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 9,
  parameter int LINE_BEATS = 2
) (
  input  logic         cpu_clk_g,
  input  logic         rst,
  input  logic [31:0]  dcache_addr,
  input  logic         dcache_re,
  input  logic [3:0]   dcache_we,
  input  logic [31:0]  dcache_din,
  output logic [31:0]  dcache_dout,
  output logic         stall,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic         mem_req_rnw,
  output logic [31:0]  mem_req_addr,
  output logic [31:0]  mem_req_data,
  output logic [3:0]   mem_req_mask,
  input  logic         mem_resp_valid,
  input  logic [127:0] mem_resp_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 5;

  state_e                 state_q, state_d;
  logic [LINES-1:0]       valid_q;
  logic                   req_valid_q, req_re_q;
  logic [3:0]             req_we_q;
  logic [31:0]            req_addr_q, req_din_q;
  logic                   wr_hit_q;
  logic [31:0]            dout_q;
  logic                   fwd_valid_q;
  logic [INDEX_BITS-1:0]  fwd_idx_q;
  logic [OFFSET_BITS-1:0] fwd_off_q;
  logic [3:0]             fwd_mask_q;
  logic [31:0]            fwd_data_q;

  logic [TAG_W-1:0]       tag_mem [LINES];
  logic [TAG_W-1:0]       tag_rd_q;

  logic [31:0]            rd_idx_full, req_idx_full, req_tag_full;
  logic [INDEX_BITS-1:0]  rd_idx, req_idx;
  logic [TAG_W-1:0]       req_tag;
  logic [OFFSET_BITS-1:0] req_off;
  logic                   req_is_wr, req_is_rd, hit;
  logic                   accept, wr_en, fill_valid, fill_last;
  logic [255:0]           line_rd, fill_line;
  logic [31:0]            hit_word, fill_word;

  assign rd_idx_full  = addr_index(dcache_addr);
  assign rd_idx       = rd_idx_full[INDEX_BITS-1:0];
  assign req_idx_full = addr_index(req_addr_q);
  assign req_idx      = req_idx_full[INDEX_BITS-1:0];
  assign req_tag_full = addr_tag(req_addr_q, INDEX_BITS);
  assign req_tag      = req_tag_full[TAG_W-1:0];
  assign req_off      = addr_offset(req_addr_q);

  assign req_is_wr  = req_valid_q && (|req_we_q);
  assign req_is_rd  = req_valid_q && req_re_q && !(|req_we_q);
  assign hit        = valid_q[req_idx] && (tag_rd_q == req_tag);
  assign fill_valid = (state_q == ST_FILL_WAIT) && mem_resp_valid;
  assign fill_word  = fill_line[{req_off, 5'b0} +: 32];

  assign mem_req_addr = mem_req_rnw ? {req_addr_q[31:5], 5'b0} : {req_addr_q[31:2], 2'b0};
  assign mem_req_data = req_din_q;
  assign mem_req_mask = req_we_q;

  // A read issued in the same cycle as a write hit sees the old RAM word,
  // so the written bytes are replayed onto it one cycle later.
  always_comb begin
    hit_word = line_rd[{req_off, 5'b0} +: 32];
    if (fwd_valid_q && (fwd_idx_q == req_idx) && (fwd_off_q == req_off)) begin
      for (int b = 0; b < 4; b++) begin
        if (fwd_mask_q[b]) hit_word[b*8 +: 8] = fwd_data_q[b*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_rnw   = 1'b0;
    accept        = 1'b0;
    wr_en         = 1'b0;
    dcache_dout   = dout_q;
    case (state_q)
      ST_LOOKUP: begin
        if (req_is_wr) begin
          mem_req_valid = 1'b1;
          stall         = !mem_req_ready;
          if (mem_req_ready) wr_en = hit;
          else state_d = ST_WRITE_REQ;
        end else if (req_is_rd) begin
          if (hit) begin
            dcache_dout = hit_word;
          end else begin
            stall   = 1'b1;
            state_d = ST_FILL_REQ;
          end
        end
        accept = !stall;
      end
      ST_WRITE_REQ: begin
        mem_req_valid = 1'b1;
        stall         = !mem_req_ready;
        if (mem_req_ready) begin
          wr_en   = wr_hit_q;
          accept  = 1'b1;
          state_d = ST_LOOKUP;
        end
      end
      ST_FILL_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_rnw   = 1'b1;
        if (mem_req_ready) state_d = ST_FILL_WAIT;
      end
      ST_FILL_WAIT: begin
        stall = 1'b1;
        if (fill_last) state_d = ST_FILL_DONE;
      end
      ST_FILL_DONE: begin
        dcache_dout = fill_word;
        accept      = 1'b1;
        state_d     = ST_LOOKUP;
      end
      default: state_d = ST_LOOKUP;
    endcase
  end

  always_ff @(posedge cpu_clk_g) begin
    if (rst) begin
      state_q     <= ST_LOOKUP;
      valid_q     <= '0;
      req_valid_q <= 1'b0;
      req_re_q    <= 1'b0;
      req_we_q    <= '0;
      req_addr_q  <= '0;
      req_din_q   <= '0;
      wr_hit_q    <= 1'b0;
      dout_q      <= '0;
      fwd_valid_q <= 1'b0;
      fwd_idx_q   <= '0;
      fwd_off_q   <= '0;
      fwd_mask_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      dout_q      <= dcache_dout;
      fwd_valid_q <= wr_en;
      if (accept) begin
        req_valid_q <= dcache_re | (|dcache_we);
        req_re_q    <= dcache_re;
        req_we_q    <= dcache_we;
        req_addr_q  <= dcache_addr;
        req_din_q   <= dcache_din;
      end
      if (state_q == ST_LOOKUP) wr_hit_q <= hit;
      if (fill_last) valid_q[req_idx] <= 1'b1;
      if (wr_en) begin
        fwd_idx_q  <= req_idx;
        fwd_off_q  <= req_off;
        fwd_mask_q <= req_we_q;
        fwd_data_q <= req_din_q;
      end
    end
  end

  always_ff @(posedge cpu_clk_g) begin
    if (fill_last) tag_mem[req_idx] <= req_tag;
    tag_rd_q <= tag_mem[rd_idx];
  end

  dcache_data_ram #(
    .INDEX_BITS(INDEX_BITS),
    .LINE_BEATS(LINE_BEATS)
  ) u_data (
    .clk_i       (cpu_clk_g),
    .rst_i       (rst),
    .rd_idx_i    (rd_idx),
    .rd_line_o   (line_rd),
    .wr_en_i     (wr_en),
    .wr_idx_i    (req_idx),
    .wr_off_i    (req_off),
    .wr_mask_i   (req_we_q),
    .wr_data_i   (req_din_q),
    .fill_valid_i(fill_valid),
    .fill_idx_i  (req_idx),
    .fill_data_i (mem_resp_data),
    .fill_last_o (fill_last),
    .fill_line_o (fill_line)
  );

`ifdef DCACHE_STATS_EN
  logic        count_hit, count_miss;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  assign count_hit  = (state_q == ST_LOOKUP) && req_is_rd && hit;
  assign count_miss = (state_q == ST_LOOKUP) && req_is_rd && !hit;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  always_ff @(posedge cpu_clk_g) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (count_hit && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_q <= hit_cnt_q + 1'b1;
      if (count_miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end
`endif

endmodule
